// File: rtl/img_stream_io.sv
// img_stream_io: frame fetch and write-back bridge between host image memory and a streaming filter core
module img_stream_io #(
   parameter int N_PIX      = 65536,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic [15:0] in_addr,
   input  logic [7:0]  in_data,
   output logic        out_valid,
   output logic [15:0] out_addr,
   output logic [7:0]  out_data,
   output logic        finish,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic [7:0]  pix_data,
   output logic [15:0] pix_addr,
   input  logic        res_valid,
   output logic        res_ready,
   input  logic [7:0]  res_data
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [16:0] LAST = 17'(N_PIX - 1);
   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
   state_t        r_state;
   logic [16:0]   r_rd_cnt, r_wr_cnt;
   logic [15:0]   r_in_addr, r_cap_addr, r_out_addr;
   logic [7:0]    r_out_data;
   logic          r_iss, r_cap, r_out_valid, r_finish;
   logic [7:0]    r_fd [FIFO_DEPTH];
   logic [15:0]   r_fa [FIFO_DEPTH];
   logic [AW-1:0] r_wp, r_rp;
   logic [AW:0]   r_cnt;
   logic [AW+1:0] w_used;
   logic          w_issue, w_pop, w_accept;
   // r_iss: address on in_addr is a fresh read; r_cap: its data is on in_data now
   assign w_used    = (AW+2)'(r_cnt) + (AW+2)'(r_iss) + (AW+2)'(r_cap);
   assign w_issue   = r_state == FETCH && in_valid && w_used < (AW+2)'(FIFO_DEPTH);
   assign w_pop     = pix_valid && pix_ready;
   assign w_accept  = res_valid && res_ready;
   assign res_ready = r_state == FETCH || r_state == DRAIN;
   assign pix_valid = r_cnt != '0;
   assign pix_data  = r_fd[r_rp];
   assign pix_addr  = r_fa[r_rp];
   assign in_addr   = r_in_addr;
   assign out_valid = r_out_valid;
   assign out_addr  = r_out_addr;
   assign out_data  = r_out_data;
   assign finish    = r_finish;
   // frame sequencing, read issue pipeline and one-cycle result write-back
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_rd_cnt    <= '0;
         r_wr_cnt    <= '0;
         r_in_addr   <= '0;
         r_cap_addr  <= '0;
         r_iss       <= 1'b0;
         r_cap       <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_addr  <= '0;
         r_out_data  <= '0;
         r_finish    <= 1'b0;
      end else begin
         r_state <= (r_state == IDLE && in_valid) ? FETCH :
                    (w_accept && r_wr_cnt == LAST) ? DONE :
                    (w_issue && r_rd_cnt == LAST) ? DRAIN : r_state;
         r_iss <= w_issue;
         r_cap <= r_iss;
         if (r_iss) r_cap_addr <= r_in_addr;
         if (w_issue) begin
            r_in_addr <= r_rd_cnt[15:0];
            r_rd_cnt  <= r_rd_cnt + 17'd1;
         end
         r_out_valid <= w_accept;
         if (w_accept) begin
            r_out_data <= res_data;
            r_out_addr <= r_wr_cnt[15:0];
            r_wr_cnt   <= r_wr_cnt + 17'd1;
         end
         r_finish <= r_state == DONE;
      end
   end
   // read-return FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         r_wp  <= r_wp + AW'(r_cap);
         r_rp  <= r_rp + AW'(w_pop);
         r_cnt <= r_cnt + (AW+1)'(r_cap) - (AW+1)'(w_pop);
      end
   end
   // read-return FIFO storage, tagged with the pixel address
   always_ff @(posedge clk) begin
      if (r_cap) begin
         r_fd[r_wp] <= in_data;
         r_fa[r_wp] <= r_cap_addr;
      end
   end
endmodule

// File: tb/tb_img_stream_io.sv
// tb_img_stream_io: directed stimulus with a host memory, an echo filter core and a frame-level reference model
module tb_img_stream_io;
   localparam int N_PIX = 65536;
   logic        clk = 1'b0, rst = 1'b0, in_valid = 1'b0, pix_ready = 1'b0, res_valid = 1'b0;
   logic [7:0]  in_data = 8'd0, res_data = 8'd0;
   logic [15:0] in_addr, out_addr, pix_addr;
   logic [7:0]  out_data, pix_data;
   logic        out_valid, finish, pix_valid, res_ready;
   int          checks = 0, errors = 0;
   int          mode = 0;
   always #5 clk = ~clk;
   img_stream_io #(.N_PIX(N_PIX), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
      .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data), .finish(finish),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_addr(pix_addr),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   // host memory (mem[a] = a[7:0], one-cycle read) and filter core (mode 1 echo after 3 cycles, 2 alternate 0xA5, 3 constant valid)
   initial begin
      logic [15:0] s_addr;
      logic        s_pop;
      logic [7:0]  s_pd;
      logic [8:0]  pipe [3];
      bit          tog;
      tog = 1'b0;
      for (int i = 0; i < 3; i++) pipe[i] = '0;
      forever begin
         @(negedge clk);
         s_addr = in_addr;
         s_pop  = rst && pix_valid && pix_ready;
         s_pd   = pix_data;
         @(posedge clk);
         #1;
         in_data = s_addr[7:0];
         pipe[2] = pipe[1];
         pipe[1] = pipe[0];
         pipe[0] = {s_pop, s_pd};
         tog = !tog;
         res_valid = (mode == 1) ? pipe[2][8] : (mode == 2) ? tog : (mode == 3);
         res_data  = (mode == 1) ? pipe[2][7:0] : 8'hA5;
      end
   end
   // reference model: frame progress from counts of pops and accepted results
   logic        e_ov = 1'b0, e_fin = 1'b0, e_rst = 1'b0, armed = 1'b0, started = 1'b0;
   logic        p_rst = 1'b0, p_iv = 1'b0;
   logic [15:0] e_oa = '0, p_ia = '0;
   logic [7:0]  e_od = '0;
   int          n_acc = 0, n_str = 0, n_pop = 0;
   always @(negedge clk) begin
      if (armed) begin
         chk("out_valid", out_valid, e_ov);
         if (e_ov) begin
            chk("out_addr", out_addr, e_oa);
            chk("out_data", out_data, e_od);
         end
         chk("finish", finish, e_fin);
         chk("res_ready", res_ready, started && n_acc < N_PIX);
         if (e_rst) begin
            chk("rst in_addr", in_addr, 0);
            chk("rst out_addr", out_addr, 0);
            chk("rst out_data", out_data, 0);
            chk("rst pix_valid", pix_valid, 0);
         end
         if (p_rst) begin
            chk("in_addr step", int'(in_addr) == int'(p_ia) || int'(in_addr) == int'(p_ia) + 1, 1);
            chk("in_addr credit", int'(in_addr) <= n_pop + 3, 1);
            if (!p_iv && !in_valid) chk("in_addr hold", in_addr, p_ia);
         end
      end
      if (rst && pix_valid && pix_ready) begin
         chk("pix_addr", pix_addr, n_pop[15:0]);
         chk("pix_data", pix_data, n_pop[7:0]);
         n_pop++;
      end
      n_str += int'(e_ov);
      if (!rst) begin
         e_rst = 1'b1; e_ov = 1'b0; e_fin = 1'b0; started = 1'b0;
         n_acc = 0; n_str = 0; n_pop = 0;
      end else begin
         e_rst = 1'b0;
         e_ov  = res_valid && started && n_acc < N_PIX;
         if (e_ov) begin
            e_od = res_data;
            e_oa = n_acc[15:0];
            n_acc++;
         end
         e_fin = n_str == N_PIX;
         if (in_valid) started = 1'b1;
      end
      p_ia = in_addr; p_iv = in_valid; p_rst = rst; armed = 1'b1;
   end
   // directed scenarios
   initial begin
      int n, s, nstr;
      logic prev_ov;
      logic [15:0] last_a;
      logic [7:0]  last_d;
      cyc(3);
      chk("reset in_addr", in_addr, 0);
      chk("reset out_valid", out_valid, 0);
      chk("reset finish", finish, 0);
      chk("reset pix_valid", pix_valid, 0);
      chk("reset res_ready", res_ready, 0);
      rst = 1'b1;
      cyc(3);
      chk("idle no issue in_addr", in_addr, 0);
      chk("idle pix_valid", pix_valid, 0);
      in_valid = 1'b1;
      cyc(20);
      chk("stall in_addr", in_addr, 3);
      chk("stall pix_valid", pix_valid, 1);
      chk("stall pix_addr", pix_addr, 0);
      pix_ready = 1'b1;
      mode = 1;
      for (n = 0; n < 300 && in_addr != 16'd100; n++) cyc(1);
      chk("reach addr 100", in_addr, 100);
      in_valid = 1'b0;
      cyc(10);
      chk("gap in_addr", in_addr, 100);
      chk("gap drained", pix_valid, 0);
      in_valid = 1'b1;
      for (n = 0; n < 10 && in_addr == 16'd100; n++) cyc(1);
      chk("resume in_addr", in_addr, 101);
      mode = 2;
      cyc(4);
      s = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         if (out_valid) begin
            s++;
            chk("alt out_data", out_data, 8'hA5);
         end
      end
      chk("alt strobes", s, 10);
      pix_ready = 1'b0;
      cyc(3);
      mode = 3;
      cyc(2);
      chk("pre-reset out_valid", out_valid, 1);
      chk("pre-reset pix_valid", pix_valid, 1);
      rst = 1'b0;
      cyc(1);
      chk("mid reset in_addr", in_addr, 0);
      chk("mid reset out_valid", out_valid, 0);
      chk("mid reset out_addr", out_addr, 0);
      chk("mid reset out_data", out_data, 0);
      chk("mid reset pix_valid", pix_valid, 0);
      chk("mid reset finish", finish, 0);
      cyc(3);
      rst = 1'b1;
      mode = 1;
      pix_ready = 1'b1;
      nstr = 0; prev_ov = 1'b0; last_a = '0; last_d = '0;
      for (n = 0; n < N_PIX + 16 && !finish; n++) begin
         prev_ov = out_valid;
         cyc(1);
         if (out_valid) begin
            nstr++;
            last_a = out_addr;
            last_d = out_data;
         end
      end
      chk("frame finished", finish, 1);
      chk("frame strobes", nstr, N_PIX);
      chk("last out_addr", last_a, 16'hFFFF);
      chk("last out_data", last_d, 8'hFF);
      chk("finish after last strobe", prev_ov, 1);
      chk("frame throughput", n <= N_PIX + 12, 1);
      mode = 3;
      for (int i = 0; i < 5; i++) begin
         cyc(1);
         chk("done res_ready", res_ready, 0);
         chk("done out_valid", out_valid, 0);
         chk("done finish", finish, 1);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/img_stream_io.md
IMG_STREAM_IO -- requirements
Module: img_stream_io

Interface
REQ-001 Parameter: N_PIX, 65536, pixels per frame (raster order, 256x256, address = row*256+col).
REQ-002 Parameter: FIFO_DEPTH, 4, read-return FIFO entries (power of two, >= 2).
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-low reset (sampled on rising clk edge).
REQ-005 Port: in_valid  input  1  host frame available; fetching is permitted only while high.
REQ-006 Port: in_addr  output  16  pixel read address to host image memory.
REQ-007 Port: in_data  input  8  host read data; valid exactly one cycle after in_addr is presented.
REQ-008 Port: out_valid  output  1  result write strobe to host.
REQ-009 Port: out_addr  output  16  result write address.
REQ-010 Port: out_data  output  8  result write data.
REQ-011 Port: finish  output  1  frame complete; host stops the run on it.
REQ-012 Port: pix_valid / pix_ready / pix_data[7:0] / pix_addr[15:0]  out / in / out / out  pixel stream to filter core.
REQ-013 Port: res_valid / res_ready / res_data[7:0]  in / out / in  result stream from filter core, raster order.

Function
REQ-014 States: IDLE, FETCH, DRAIN, DONE; reset enters IDLE.
REQ-015 IDLE -> FETCH on first cycle in_valid=1; FETCH -> DRAIN after read N_PIX-1 issued; DRAIN -> DONE when N_PIX-th result written; DONE holds until reset.
REQ-016 Read issue in a cycle: state FETCH, in_valid=1, and (fifo_count + inflight) < FIFO_DEPTH; otherwise no issue.
REQ-017 in_addr: rd_cnt value presented on issue; holds last value when not issuing; rd_cnt increments per issue, never wraps past N_PIX-1.
REQ-018 Capture: one cycle after an issue, in_data pushed into FIFO tagged with its address; non-issue cycles push nothing.
REQ-019 FIFO never overflows (credit rule REQ-016); push and pop in same cycle allowed, count unchanged.
REQ-020 pix_valid = FIFO non-empty; pix_data/pix_addr = head entry; pop on pix_valid & pix_ready; stream order strictly ascending address.
REQ-021 in_valid low during FETCH: issue pauses, in-flight read still captured, resumes at next address when in_valid returns; no address skipped or repeated.
REQ-022 res_ready = 1 in FETCH and DRAIN, 0 in IDLE and DONE.
REQ-023 Result accept (res_valid & res_ready): next cycle out_valid=1, out_data=res_data, out_addr=wr_cnt; wr_cnt increments; out_valid=0 in cycles with no accept.
REQ-024 Write path latency exactly 1 cycle; back-to-back accepts give back-to-back strobes with consecutive addresses.
REQ-025 Results arriving before all reads issued are legal and written immediately.
REQ-026 finish rises in the cycle after the N_PIX-th out_valid strobe (with DONE), stays high until reset.
REQ-027 res_valid in IDLE/DONE ignored; no out_valid in those states.
REQ-028 Counters 17 bits internally so N_PIX=65536 terminal count is representable; addresses output as low 16 bits.

Reset
REQ-029 rst=0 at a rising edge: state IDLE, in_addr=0, out_valid=0, out_addr=0, out_data=0, finish=0, pix_valid=0, FIFO empty, rd_cnt=wr_cnt=0, inflight cleared.
REQ-030 Reset mid-frame discards FIFO contents and any in-flight read; capture of a pending read return suppressed in the cycle after reset.
REQ-031 After reset release, no issue until in_valid sampled high.

Verification
REQ-032 Reset then in_valid=1, pix_ready=1, host memory mem[a]=a[7:0], core echoes pix_data with 3-cycle delay -> in_addr 0,1,2,... one per cycle; out_addr/out_data 0/0,1/1,...,65535/255; finish high one cycle after last strobe.
REQ-033 pix_ready held 0 from start -> exactly FIFO_DEPTH (4) reads issued (addrs 0-3), in_addr holds 3, pix_valid=1 with pix_addr=0; release pix_ready -> stream resumes at addr 4 with no gaps.
REQ-034 in_valid dropped for 10 cycles after addr 100 issued -> addr 100 data captured, no issues during gap, next issue addr 101.
REQ-035 res_valid on alternate cycles with data 0xA5 -> out_valid alternates, out_data=0xA5, out_addr increments by 1 per strobe only.
REQ-036 rst=0 asserted while FIFO holds 3 entries and out_valid=1 -> next cycle all outputs at reset values, pix_valid=0; restart fetches from addr 0.
REQ-037 After finish: res_valid=1 for 5 cycles -> res_ready=0, out_valid stays 0, finish stays 1.
